// File: rtl/pipereg_pkg.sv
// Shared pipeline-register types: FSM states, control-field positions, default widths
// and saturating-increment helpers used by the elastic stage and the hazard unit.
package pipereg_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 2;
  localparam int DEF_RD_W      = 5;
  localparam int DEF_CTRL_W    = 3;

  localparam int CTRL_REG_WRITE     = 0;
  localparam int CTRL_MEM_TO_REG_LO = 1;
  localparam int CTRL_MEM_TO_REG_HI = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  function automatic logic reg_write_of(input logic [DEF_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REG_WRITE];
  endfunction

  function automatic logic [1:0] mem_to_reg_of(input logic [DEF_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_TO_REG_HI:CTRL_MEM_TO_REG_LO];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipereg_elastic_stage_if.sv
// Valid/ready payload bundle between two pipeline stages; master drives the entry,
// slave returns ready.
interface pipereg_elastic_stage_if
  import pipereg_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int RD_W      = DEF_RD_W,
  parameter int CTRL_W    = DEF_CTRL_W
) ();

  logic                        valid;
  logic                        ready;
  logic [NUM_WORDS*WORD_W-1:0] words;
  logic [RD_W-1:0]             rd;
  logic [CTRL_W-1:0]           ctrl;

  modport master (output valid, output words, output rd, output ctrl, input ready);
  modport slave  (input valid, input words, input rd, input ctrl, output ready);

endinterface

// File: rtl/pipereg_entry.sv
// One payload slot of the elastic stage (words, rd, ctrl); clear wins over load so a
// freed slot always reads back as an all-zero bubble.
module pipereg_entry
  import pipereg_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int RD_W      = DEF_RD_W,
  parameter int CTRL_W    = DEF_CTRL_W
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        clear_i,
  input  logic                        load_i,
  input  logic [NUM_WORDS*WORD_W-1:0] words_i,
  input  logic [RD_W-1:0]             rd_i,
  input  logic [CTRL_W-1:0]           ctrl_i,
  output logic [NUM_WORDS*WORD_W-1:0] words_o,
  output logic [RD_W-1:0]             rd_o,
  output logic [CTRL_W-1:0]           ctrl_o
);

  // Payload storage with reset/clear to zero and load-enable
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      words_o <= '0;
      rd_o    <= '0;
      ctrl_o  <= '0;
    end else if (load_i) begin
      words_o <= words_i;
      rd_o    <= rd_i;
      ctrl_o  <= ctrl_i;
    end else begin
      words_o <= words_o;
      rd_o    <= rd_o;
      ctrl_o  <= ctrl_o;
    end
  end

endmodule

// File: rtl/pipereg_elastic_stage.sv
// Elastic two-entry pipeline stage (MAIN + SKID) with registered ready, flush and bubble zeroing.
// Optional perf counters are built when PIPEREG_PERF_EN is defined.
module pipereg_elastic_stage
  import pipereg_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int RD_W      = DEF_RD_W,
  parameter int CTRL_W    = DEF_CTRL_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  pipereg_elastic_stage_if.slave   up,
  pipereg_elastic_stage_if.master  dn,
  output logic [31:0]              stall_cnt_o,
  output logic [15:0]              flush_cnt_o
);

  localparam int DATA_W = NUM_WORDS * WORD_W;

  state_e state_r;
  state_e state_nxt_s;
  logic   ready_r;
  logic   valid_r;
  logic   in_fire_s;
  logic   out_fire_s;
  logic   main_load_s;
  logic   main_clr_s;
  logic   main_sel_skid_s;
  logic   skid_load_s;
  logic   skid_clr_s;

  logic [DATA_W-1:0] main_words_d_s;
  logic [RD_W-1:0]   main_rd_d_s;
  logic [CTRL_W-1:0] main_ctrl_d_s;
  logic [DATA_W-1:0] skid_words_s;
  logic [RD_W-1:0]   skid_rd_s;
  logic [CTRL_W-1:0] skid_ctrl_s;

  assign in_fire_s  = up.valid & ready_r;
  assign out_fire_s = valid_r & dn.ready;
  assign up.ready   = ready_r;
  assign dn.valid   = valid_r;

  // Next-state and entry load/clear decode; flush discards everything held plus the input
  always_comb begin
    state_nxt_s     = state_r;
    main_load_s     = 1'b0;
    main_clr_s      = 1'b0;
    main_sel_skid_s = 1'b0;
    skid_load_s     = 1'b0;
    skid_clr_s      = 1'b0;
    if (flush_i) begin
      state_nxt_s = ST_EMPTY;
      main_clr_s  = 1'b1;
      skid_clr_s  = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_load_s = 1'b1;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_load_s = 1'b1;
            state_nxt_s = ST_ONE;
          end else if (in_fire_s) begin
            skid_load_s = 1'b1;
            state_nxt_s = ST_TWO;
          end else if (out_fire_s) begin
            main_clr_s  = 1'b1;
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          // ready_o is low here, so only the head can move
          if (out_fire_s) begin
            main_load_s     = 1'b1;
            main_sel_skid_s = 1'b1;
            skid_clr_s      = 1'b1;
            state_nxt_s     = ST_ONE;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_clr_s  = 1'b1;
          skid_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // MAIN refills either from the skid slot or straight from upstream
  always_comb begin
    main_words_d_s = up.words;
    main_rd_d_s    = up.rd;
    main_ctrl_d_s  = up.ctrl;
    if (main_sel_skid_s) begin
      main_words_d_s = skid_words_s;
      main_rd_d_s    = skid_rd_s;
      main_ctrl_d_s  = skid_ctrl_s;
    end else begin
      main_words_d_s = up.words;
      main_rd_d_s    = up.rd;
      main_ctrl_d_s  = up.ctrl;
    end
  end

  // State register plus registered ready/valid derived from the next state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_EMPTY;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s != ST_TWO);
      valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  pipereg_entry #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .RD_W(RD_W), .CTRL_W(CTRL_W)
  ) u_main (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (main_clr_s),
    .load_i  (main_load_s),
    .words_i (main_words_d_s),
    .rd_i    (main_rd_d_s),
    .ctrl_i  (main_ctrl_d_s),
    .words_o (dn.words),
    .rd_o    (dn.rd),
    .ctrl_o  (dn.ctrl)
  );

  pipereg_entry #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .RD_W(RD_W), .CTRL_W(CTRL_W)
  ) u_skid (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (skid_clr_s),
    .load_i  (skid_load_s),
    .words_i (up.words),
    .rd_i    (up.rd),
    .ctrl_i  (up.ctrl),
    .words_o (skid_words_s),
    .rd_o    (skid_rd_s),
    .ctrl_o  (skid_ctrl_s)
  );

`ifdef PIPEREG_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating perf counters, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (valid_r && !dn.ready) begin
        stall_cnt_r <= sat_inc32(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_i && (state_r != ST_EMPTY)) begin
        flush_cnt_r <= sat_inc16(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipereg_elastic_stage.sv
// Bench for pipereg_elastic_stage: directed scenarios plus random traffic against a
// queue-based model of a 2-deep FIFO stage.
module tb_pipereg_elastic_stage;
  import pipereg_pkg::*;

  localparam int WORD_W = 32, NUM_WORDS = 2, RD_W = 5, CTRL_W = 3;
  localparam int DW = WORD_W * NUM_WORDS;

  typedef struct packed {
    logic [DW-1:0]     w;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] c;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  pipereg_elastic_stage_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .RD_W(RD_W), .CTRL_W(CTRL_W)) up_if ();
  pipereg_elastic_stage_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .RD_W(RD_W), .CTRL_W(CTRL_W)) dn_if ();

  pipereg_elastic_stage #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .up          (up_if),
    .dn          (dn_if),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   m_stall = 0;
  int   m_flush = 0;
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef PIPEREG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic ent_t head();
    ent_t z;
    z = '0;
    if (q.size() == 0) return z;
    return q[0];
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.w  = {$urandom(), $urandom()};
    e.rd = RD_W'($urandom_range(0, 31));
    e.c  = CTRL_W'($urandom_range(0, 7));
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e, input logic rdy, input logic fl);
    up_if.valid = v;
    up_if.words = e.w;
    up_if.rd    = e.rd;
    up_if.ctrl  = e.c;
    dn_if.ready = rdy;
    flush_i     = fl;
  endtask

  // Reference: the stage is a FIFO of depth 2; ready means "fewer than two held"
  task automatic model_edge();
    bit acc, take;
    ent_t cur;
    if (reset_i) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      cur  = '{w: up_if.words, rd: up_if.rd, c: up_if.ctrl};
      acc  = up_if.valid && (q.size() < 2);
      take = (q.size() > 0) && dn_if.ready;
      if (PERF && q.size() > 0 && !dn_if.ready) m_stall++;
      if (PERF && flush_i && q.size() > 0) m_flush++;
      if (flush_i) q.delete();
      else begin
        if (take) void'(q.pop_front());
        if (acc) q.push_back(cur);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    ent_t e;
    e = rand_ent();
    drive(1'b1, e, 1'b1, 1'b1);
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", dn_if.valid); end
    n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", up_if.ready); end
    n_checks++; if ({dn_if.words, dn_if.rd, dn_if.ctrl} !== '0) begin n_fail++; $display("FAIL reset_payload got=%h exp=0", {dn_if.words, dn_if.rd, dn_if.ctrl}); end
    n_checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    ent_t p;
    p = '{w: {32'h0000_0001, 32'h0000_000A}, rd: 5'd5, c: 3'b001};
    drive(1'b1, p, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", dn_if.valid); end
    n_checks++; if ({dn_if.words, dn_if.rd, dn_if.ctrl} !== p) begin n_fail++; $display("FAIL single_payload got=%h exp=%h", {dn_if.words, dn_if.rd, dn_if.ctrl}, p); end
    model_edge();
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (dn_if.valid !== 1'b0 || {dn_if.words, dn_if.rd, dn_if.ctrl} !== '0) begin n_fail++; $display("FAIL single_bubble got=%b/%h exp=0/0", dn_if.valid, {dn_if.words, dn_if.rd, dn_if.ctrl}); end
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    ent_t sent[8];
    int rx;
    rx = 0;
    for (int i = 0; i < 8; i++) sent[i] = rand_ent();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, sent[i], 1'b1, 1'b0);
      else drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, up_if.ready); end
      n_checks++; if (dn_if.valid !== (i >= 1 && i <= 8)) begin n_fail++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, dn_if.valid, (i >= 1 && i <= 8)); end
      if (dn_if.valid && rx < 8) begin
        n_checks++; if ({dn_if.words, dn_if.rd, dn_if.ctrl} !== sent[rx]) begin n_fail++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", rx, {dn_if.words, dn_if.rd, dn_if.ctrl}, sent[rx]); end
        rx++;
      end
      model_edge();
      @(posedge clk); #1;
    end
    n_checks++; if (rx !== 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", rx); end
  endtask

  task automatic test_backpressure();
    ent_t e[3];
    logic exp_rdy[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_vld[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   exp_idx[7] = '{-1, 0, 0, 0, 1, 2, -1};
    ent_t exp_p;
    for (int i = 0; i < 3; i++) e[i] = rand_ent();
    for (int c = 0; c < 7; c++) begin
      if (c < 2) drive(1'b1, e[c], 1'b0, 1'b0);
      else if (c == 2) drive(1'b1, e[2], 1'b0, 1'b0);
      else if (c < 5) drive(1'b1, e[2], 1'b1, 1'b0);
      else drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      exp_p = (exp_idx[c] < 0) ? ent_t'('0) : e[exp_idx[c]];
      n_checks++; if (up_if.ready !== exp_rdy[c]) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, up_if.ready, exp_rdy[c]); end
      n_checks++; if (dn_if.valid !== exp_vld[c]) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", c, dn_if.valid, exp_vld[c]); end
      n_checks++; if ({dn_if.words, dn_if.rd, dn_if.ctrl} !== exp_p) begin n_fail++; $display("FAIL bp_payload cyc=%0d got=%h exp=%h", c, {dn_if.words, dn_if.rd, dn_if.ctrl}, exp_p); end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, rand_ent(), 1'b0, 1'b0); tick();
    drive(1'b1, rand_ent(), 1'b0, 1'b0); tick();
    drive(1'b1, rand_ent(), 1'b1, 1'b1);
    @(negedge clk);
    n_checks++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_ready got=%b exp=0", up_if.ready); end
    model_edge();
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++; if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1) begin n_fail++; $display("FAIL flush_state cyc=%0d got=v%b r%b exp=v0 r1", c, dn_if.valid, up_if.ready); end
      n_checks++; if ({dn_if.words, dn_if.rd, dn_if.ctrl} !== '0) begin n_fail++; $display("FAIL flush_payload got=%h exp=0", {dn_if.words, dn_if.rd, dn_if.ctrl}); end
      n_checks++; if (flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, PERF ? 1 : 0); end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, rand_ent(), 1'b0, 1'b0); tick();
    drive(1'b1, rand_ent(), 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (dn_if.valid !== 1'b0 || up_if.ready !== 1'b1) begin n_fail++; $display("FAIL rstmid cyc=%0d got=v%b r%b exp=v0 r1", c, dn_if.valid, up_if.ready); end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf_stall();
    do_reset();
    drive(1'b1, rand_ent(), 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) tick();
    @(negedge clk);
    n_checks++; if (stall_cnt !== (PERF ? 32'd10 : 32'd0)) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? 10 : 0); end
    n_checks++; if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold got=%b exp=1", dn_if.valid); end
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    ent_t exp_p;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, rand_ent(), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      reset_i = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      exp_p = head();
      n_checks++; if (dn_if.valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, dn_if.valid, q.size() > 0); end
      n_checks++; if (up_if.ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, up_if.ready, q.size() < 2); end
      n_checks++; if ({dn_if.words, dn_if.rd, dn_if.ctrl} !== exp_p) begin n_fail++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", c, {dn_if.words, dn_if.rd, dn_if.ctrl}, exp_p); end
      n_checks++; if (stall_cnt !== 32'(m_stall) || flush_cnt !== 16'(m_flush)) begin n_fail++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, flush_cnt, m_stall, m_flush); end
      model_edge();
      @(posedge clk); #1;
    end
    reset_i = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_perf_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
